// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard tracker: operand-mux select codes
// and the per-stage tracking slot record.
package fwd_pkg;

    localparam int REG_AW_DEFAULT = 5;

    // Order matches the EX-stage 3:1 operand mux inputs data0/data1/data2.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic                      valid;
        logic [REG_AW_DEFAULT-1:0] rs;
        logic [REG_AW_DEFAULT-1:0] rt;
        logic [REG_AW_DEFAULT-1:0] dst;
        logic                      regwrite;
        logic                      memread;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_cmp.sv
// Compares one EX-stage source register against the MEM and WB slots and
// returns the operand mux select; the newer MEM result wins over WB.
module fwd_cmp
    import fwd_pkg::*;
(
    input  logic                      ex_valid,
    input  logic [REG_AW_DEFAULT-1:0] src,
    input  slot_t                     mem_slot,
    input  slot_t                     wb_slot,
    output logic [1:0]                sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_slot.valid && mem_slot.regwrite && (mem_slot.dst == src);
    assign wb_hit  = wb_slot.valid  && wb_slot.regwrite  && (wb_slot.dst  == src);

    // $0 is hard-wired zero, so it is always read from the register file.
    always_comb begin
        sel = FWD_RF;
        if (ex_valid && (src != '0)) begin
            if (mem_hit) begin
                sel = FWD_MEM;
            end else if (wb_hit) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_sel_tracker.sv
// Shadows the EX/MEM/WB pipeline registers to drive the EX operand forwarding
// selects and the load-use stall for a classic 5-stage pipeline.
module fwd_sel_tracker
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_dst_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o
);

    slot_t ex_q;
    slot_t mem_q;
    slot_t wb_q;
    slot_t id_slot;
    logic  load_use;
    logic  ex_bubble;

    always_comb begin
        id_slot          = SLOT_BUBBLE;
        id_slot.valid    = 1'b1;
        id_slot.rs       = id_rs_i;
        id_slot.rt       = id_rt_i;
        id_slot.dst      = id_dst_i;
        id_slot.regwrite = id_regwrite_i;
        id_slot.memread  = id_memread_i;
    end

    // Back-pressure contract: stall_o is the only flow-control signal. While it
    // is high the upstream stages hold PC and IF/ID, so the same ID instruction
    // is presented again next cycle; this block inserts a bubble into EX meanwhile.
    assign load_use = ex_q.valid && ex_q.memread && (ex_q.dst != '0) && id_valid_i &&
                      ((ex_q.dst == id_rs_i) || (ex_q.dst == id_rt_i));

    assign ex_bubble = load_use || flush_i || !id_valid_i;
    assign stall_o   = load_use;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= SLOT_BUBBLE;
            mem_q <= SLOT_BUBBLE;
            wb_q  <= SLOT_BUBBLE;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_bubble ? SLOT_BUBBLE : id_slot;
        end
    end

    fwd_cmp u_cmp_a (
        .ex_valid (ex_q.valid),
        .src      (ex_q.rs),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (fwd_a_sel_o)
    );

    fwd_cmp u_cmp_b (
        .ex_valid (ex_q.valid),
        .src      (ex_q.rt),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel      (fwd_b_sel_o)
    );

endmodule

// File: doc/fwd_sel_tracker.md
FWD_SEL_TRACKER -- requirements
Module: fwd_sel_tracker

Interface
REQ-001 Parameter: REG_AW, 5, register-address width.
REQ-002 Port: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_i  in  1  reset; synchronous, active-high.
REQ-004 Port: id_valid_i  in  1  ID stage holds a real instruction.
REQ-005 Port: id_rs_i, id_rt_i  in  REG_AW each  ID source register addresses.
REQ-006 Port: id_dst_i  in  REG_AW  ID destination register address.
REQ-007 Port: id_regwrite_i, id_memread_i  in  1 each  ID instruction writes regfile / is a load.
REQ-008 Port: flush_i  in  1  discard the ID instruction (branch taken).
REQ-009 Port: fwd_a_sel_o, fwd_b_sel_o  out  2 each  select for the EX-stage 3:1 operand muxes (0 regfile, 1 EX/MEM result, 2 MEM/WB result).
REQ-010 Port: stall_o  out  1  load-use hazard; upstream SHALL hold PC and IF/ID.

Function
REQ-011 Block SHALL keep three tracking slots EX, MEM, WB; each holds valid, rs, rt, dst, regwrite, memread (rs/rt used in EX only).
REQ-012 Each clock: WB<=MEM, MEM<=EX, EX<=ID fields, unless REQ-014/REQ-015 insert a bubble.
REQ-013 stall_o SHALL be combinational: 1 iff EX.valid & EX.memread & EX.dst!=0 & id_valid_i & (EX.dst==id_rs_i | EX.dst==id_rt_i).
REQ-014 When stall_o=1, EX SHALL load a bubble (valid=0, regwrite=0, memread=0); MEM and WB still advance.
REQ-015 When flush_i=1, EX SHALL load a bubble; flush_i and stall_o both 1 -> single bubble, same result.
REQ-016 fwd_a_sel_o SHALL be combinational from slots: 1 if MEM.valid & MEM.regwrite & MEM.dst!=0 & MEM.dst==EX.rs; else 2 if same test on WB; else 0.
REQ-017 fwd_b_sel_o SHALL follow REQ-016 using EX.rt.
REQ-018 MEM match SHALL take priority over WB match (newest value wins).
REQ-019 Register 0 SHALL never be forwarded; select 3 SHALL never be driven.
REQ-020 When EX.valid=0, both selects SHALL be 0.
REQ-021 Latency: selects valid in the same cycle the instruction occupies EX; zero added cycles.

Reset
REQ-022 On rst_i=1 at a clock edge, all slots SHALL become bubbles (all fields 0).
REQ-023 During and after reset, fwd_a_sel_o=0, fwd_b_sel_o=0, stall_o=0 until a valid load enters EX.
REQ-024 Reset mid-stream SHALL discard all in-flight slots; no forwarding from pre-reset instructions.

Structure
REQ-025 Shared package fwd_pkg SHALL hold FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2, REG_AW default, and the slot record type.
REQ-026 One sub-module fwd_cmp (one operand address vs MEM/WB slots -> 2-bit select) SHALL be instantiated twice (A, B).
REQ-027 Select encoding SHALL match the existing 3:1 mux data0/data1/data2 order.

Verification
REQ-028 Reset: rst_i=1 two cycles with id_valid_i=1 -> selects 0, stall_o 0; first post-reset instruction sees no forwarding.
REQ-029 Back-to-back ALU: I1 dst=$8 regwrite, I2 rs=$8 -> I2 in EX gives fwd_a_sel_o=1; I3 rt=$8 one later -> fwd_b_sel_o=2.
REQ-030 Priority: I1 dst=$9, I2 dst=$9, I3 rs=$9 rt=$9 -> I3 in EX gives both selects=1.
REQ-031 Load-use: I1 load dst=$10, I2 rs=$10 -> stall_o=1 one cycle, EX bubble, then I2 in EX gives fwd_a_sel_o=2.
REQ-032 $0 and flush: I1 dst=$0 regwrite, I2 rs=$0 -> select 0; load dst=$11 with flush_i=1 -> no later stall or forward on $11.
REQ-033 Random regression vs reference model, 10k instructions, mid-run reset -> zero select/stall mismatches.
